decode: RTL and testbench

- RV32I decode stage. Consumes the fetch register outputs (pcD, instrD, validD).
- Reads operands from an internal 32x32 register file, written back from the writeback stage.
- Generates the immediate and control bundle.
- Registers everything into the decode/execute pipeline register (suffix E), with stall and flush.
- Latency is one cycle from D inputs to E outputs.

---
 rtl/decode_pkg.sv | 86 ++++++++
 rtl/decode_regfile.sv | 36 +++
 rtl/flopr.sv | 18 +
 rtl/decode.sv | 185 ++++++++++++++++++
 tb/tb_decode.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: opcodes, ALU operations, control bundle
// and the layout of the decode/execute pipeline register.
`ifndef WORD
`define WORD [31:0]
`endif

package decode_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_ADDPC = 4'd11
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_t;

    typedef struct packed {
        alu_op_t aluop;
        logic    alusrc;
        logic    regwrite;
        logic    memwrite;
        logic    memread;
        logic    branch;
        logic    jump;
        logic    jalr;
    } ctrl_t;

    // pc is the most significant field so a bubble image is {RESET_PC, zeros}.
    typedef struct packed {
        logic `WORD  pc;
        logic `WORD  rd1;
        logic `WORD  rd2;
        logic `WORD  imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
        logic [2:0]  funct3;
        logic        illegal;
        logic        valid;
    } ex_reg_t;

    localparam int EX_W = $bits(ex_reg_t);

    function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                               input logic is_reg_op);
        case (f3)
            3'b000:  return (is_reg_op && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: two read ports, one write port, x0 hardwired to zero,
// and same-cycle write-through so decode sees the value being written back.
module regfile #(
    parameter int REGS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ra1,
    input  logic [4:0] ra2,
    input  logic       we,
    input  logic [4:0] wa,
    input  logic `WORD wd,
    output logic `WORD rd1,
    output logic `WORD rd2
);

    logic `WORD mem [1:REGS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < REGS; i++) mem[i] <= '0;
        end else if (we && wa != 5'd0) begin
            mem[wa] <= wd;
        end
    end

    function automatic logic `WORD read_port(input logic [4:0] a);
        if (a == 5'd0)            return '0;
        else if (we && wa == a)   return wd;
        else                      return mem[a];
    endfunction

    assign rd1 = read_port(ra1);
    assign rd2 = read_port(ra2);

endmodule

// File: rtl/flopr.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module flopr #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= RESET_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: operand read, immediate and control generation, and the
// decode/execute pipeline register with stall and flush.
import decode_pkg::*;

module decode #(
    parameter int         REGS     = 32,
    parameter logic `WORD RESET_PC = 32'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       flushE,
    input  logic `WORD pcD,
    input  logic `WORD instrD,
    input  logic       validD,
    input  logic       weW,
    input  logic [4:0] waW,
    input  logic `WORD wdW,
    output logic `WORD pcE,
    output logic `WORD rd1E,
    output logic `WORD rd2E,
    output logic `WORD immE,
    output logic [4:0] rs1E,
    output logic [4:0] rs2E,
    output logic [4:0] rdE,
    output logic [3:0] aluopE,
    output logic       alusrcE,
    output logic       regwriteE,
    output logic       memwriteE,
    output logic       memreadE,
    output logic       branchE,
    output logic       jumpE,
    output logic       jalrE,
    output logic [2:0] funct3E,
    output logic       illegalE,
    output logic       validE
);

    localparam logic [EX_W-1:0] BUBBLE = {RESET_PC, {(EX_W-32){1'b0}}};

    logic `WORD rf_rd1, rf_rd2;
    ex_reg_t    dec, nxt, ex;
    logic       load;

    regfile #(.REGS(REGS)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (instrD[19:15]),
        .ra2   (instrD[24:20]),
        .we    (weW),
        .wa    (waW),
        .wd    (wdW),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2)
    );

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic imm_type_t imm_type_of(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            default:          return IMM_I;
        endcase
    endfunction

    function automatic logic `WORD imm_gen(input logic `WORD i);
        case (imm_type_of(i[6:0]))
            IMM_S:   return {{21{i[31]}}, i[30:25], i[11:7]};
            IMM_B:   return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'h000};
            IMM_J:   return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: return {{21{i[31]}}, i[30:20]};
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input logic `WORD i);
        ctrl_t c;
        c = '0;
        case (i[6:0])
            OP_OP: begin
                c.aluop = alu_from_funct(i[14:12], i[30], 1'b1);
                c.regwrite = 1'b1;
            end
            OP_IMM: begin
                c.aluop = alu_from_funct(i[14:12], i[30], 1'b0);
                c.regwrite = 1'b1;
                c.alusrc = 1'b1;
            end
            OP_LOAD: begin
                c.memread = 1'b1;
                c.regwrite = 1'b1;
                c.alusrc = 1'b1;
            end
            OP_STORE: begin
                c.memwrite = 1'b1;
                c.alusrc = 1'b1;
            end
            OP_BRANCH: begin
                c.aluop = ALU_SUB;
                c.branch = 1'b1;
            end
            OP_JAL: begin
                c.jump = 1'b1;
                c.regwrite = 1'b1;
            end
            OP_JALR: begin
                c.jump = 1'b1;
                c.jalr = 1'b1;
                c.regwrite = 1'b1;
                c.alusrc = 1'b1;
            end
            OP_LUI: begin
                c.aluop = ALU_PASSB;
                c.regwrite = 1'b1;
                c.alusrc = 1'b1;
            end
            OP_AUIPC: begin
                c.aluop = ALU_ADDPC;
                c.regwrite = 1'b1;
                c.alusrc = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        dec = ex_reg_t'(BUBBLE);
        if (validD) begin
            dec.pc      = pcD;
            dec.rd1     = rf_rd1;
            dec.rd2     = rf_rd2;
            dec.imm     = imm_gen(instrD);
            dec.rs1     = instrD[19:15];
            dec.rs2     = instrD[24:20];
            dec.ctrl    = decode_ctrl(instrD);
            dec.funct3  = instrD[14:12];
            dec.illegal = !is_legal(instrD[6:0]);
            dec.valid   = 1'b1;
            // rd is cleared for non-writing instructions so forwarding never matches.
            dec.rd      = dec.ctrl.regwrite ? instrD[11:7] : 5'd0;
            if (dec.illegal) dec.funct3 = 3'd0;
        end
    end

    assign nxt  = flushE ? ex_reg_t'(BUBBLE) : dec;
    assign load = en | flushE;

    flopr #(.WIDTH(EX_W), .RESET_VAL(BUBBLE)) u_ex_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load),
        .d     (nxt),
        .q     (ex)
    );

    assign pcE       = ex.pc;
    assign rd1E      = ex.rd1;
    assign rd2E      = ex.rd2;
    assign immE      = ex.imm;
    assign rs1E      = ex.rs1;
    assign rs2E      = ex.rs2;
    assign rdE       = ex.rd;
    assign aluopE    = ex.ctrl.aluop;
    assign alusrcE   = ex.ctrl.alusrc;
    assign regwriteE = ex.ctrl.regwrite;
    assign memwriteE = ex.ctrl.memwrite;
    assign memreadE  = ex.ctrl.memread;
    assign branchE   = ex.ctrl.branch;
    assign jumpE     = ex.ctrl.jump;
    assign jalrE     = ex.ctrl.jalr;
    assign funct3E   = ex.funct3;
    assign illegalE  = ex.illegal;
    assign validE    = ex.valid;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage with hand-computed expected values.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset, en, flushE, validD, weW;
    logic [31:0] pcD, instrD, wdW;
    logic [4:0]  waW;
    logic [31:0] pcE, rd1E, rd2E, immE;
    logic [4:0]  rs1E, rs2E, rdE;
    logic [3:0]  aluopE;
    logic        alusrcE, regwriteE, memwriteE, memreadE, branchE, jumpE, jalrE;
    logic [2:0]  funct3E;
    logic        illegalE, validE;

    int passed = 0;
    int total  = 0;

    decode #(.REGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .en(en), .flushE(flushE),
        .pcD(pcD), .instrD(instrD), .validD(validD),
        .weW(weW), .waW(waW), .wdW(wdW),
        .pcE(pcE), .rd1E(rd1E), .rd2E(rd2E), .immE(immE),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .aluopE(aluopE),
        .alusrcE(alusrcE), .regwriteE(regwriteE), .memwriteE(memwriteE),
        .memreadE(memreadE), .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE),
        .funct3E(funct3E), .illegalE(illegalE), .validE(validE)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic v);
        instrD = instr;
        pcD    = pc;
        validD = v;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; flushE = 1'b0; weW = 1'b0; waW = '0; wdW = '0;
        drive(32'h0, 32'h0, 1'b0);
        step(); step();
        chk("reset_valid", 32'(validE), 0);
        chk("reset_pc", pcE, 32'h0);
        chk("reset_regwrite", 32'(regwriteE), 0);
        reset = 1'b0;

        drive(32'h00500093, 32'h10, 1'b1);          // addi x1,x0,5
        step();
        chk("addi_valid", 32'(validE), 1);
        chk("addi_pc", pcE, 32'h10);
        chk("addi_imm", immE, 32'h5);
        chk("addi_rd", 32'(rdE), 1);
        chk("addi_regwrite", 32'(regwriteE), 1);
        chk("addi_alusrc", 32'(alusrcE), 1);
        chk("addi_aluop", 32'(aluopE), 0);
        chk("addi_rd1", rd1E, 32'h0);

        weW = 1'b1; waW = 5'd3; wdW = 32'hDEADBEEF;
        drive(32'h00318233, 32'h14, 1'b1);          // add x4,x3,x3 with write-through
        step();
        chk("wt_rd1", rd1E, 32'hDEADBEEF);
        chk("wt_rd2", rd2E, 32'hDEADBEEF);
        chk("wt_rdE", 32'(rdE), 4);
        chk("wt_alusrc", 32'(alusrcE), 0);

        weW = 1'b0;
        drive(32'h00318333, 32'h18, 1'b1);          // add x6,x3,x3 from stored value
        step();
        chk("stored_rd1", rd1E, 32'hDEADBEEF);

        weW = 1'b1; waW = 5'd0; wdW = 32'h1234;
        drive(32'h000002B3, 32'h1C, 1'b1);          // add x5,x0,x0
        step();
        chk("x0_bypass_rd1", rd1E, 32'h0);
        chk("x0_bypass_rd2", rd2E, 32'h0);
        weW = 1'b0;
        step();
        chk("x0_stored_rd1", rd1E, 32'h0);

        drive(32'hFE000CE3, 32'h20, 1'b1);          // beq x0,x0,-8
        step();
        chk("beq_imm", immE, 32'hFFFFFFF8);
        chk("beq_branch", 32'(branchE), 1);
        chk("beq_aluop", 32'(aluopE), 1);
        chk("beq_rd_forced0", 32'(rdE), 0);
        chk("beq_regwrite", 32'(regwriteE), 0);

        drive(32'hABCDE137, 32'h24, 1'b1);          // lui x2,0xABCDE
        step();
        chk("lui_imm", immE, 32'hABCDE000);
        chk("lui_aluop", 32'(aluopE), 10);
        chk("lui_rd", 32'(rdE), 2);

        drive(32'h001000EF, 32'h28, 1'b1);          // jal x1,+2048
        step();
        chk("jal_imm", immE, 32'h00000800);
        chk("jal_jump", 32'(jumpE), 1);
        chk("jal_jalr", 32'(jalrE), 0);
        chk("jal_alusrc", 32'(alusrcE), 0);

        drive(32'h000100E7, 32'h2C, 1'b1);          // jalr x1,0(x2)
        step();
        chk("jalr_jalr", 32'(jalrE), 1);
        chk("jalr_alusrc", 32'(alusrcE), 1);

        drive(32'h402084B3, 32'h30, 1'b1);          // sub x9,x1,x2
        step();
        chk("sub_aluop", 32'(aluopE), 1);

        drive(32'h4030D413, 32'h34, 1'b1);          // srai x8,x1,3
        step();
        chk("srai_aluop", 32'(aluopE), 7);
        chk("srai_imm", immE, 32'h403);

        drive(32'hFFC0A503, 32'h38, 1'b1);          // lw x10,-4(x1)
        step();
        chk("lw_imm", immE, 32'hFFFFFFFC);
        chk("lw_memread", 32'(memreadE), 1);
        chk("lw_funct3", 32'(funct3E), 2);

        drive(32'h00001197, 32'h3C, 1'b1);          // auipc x3,1
        step();
        chk("auipc_aluop", 32'(aluopE), 11);
        chk("auipc_imm", immE, 32'h1000);

        drive(32'h0020A623, 32'h40, 1'b1);          // sw x2,12(x1)
        step();
        chk("sw_memwrite", 32'(memwriteE), 1);
        chk("sw_imm", immE, 32'd12);
        chk("sw_rd", 32'(rdE), 0);

        en = 1'b0;
        drive(32'h00500093, 32'h44, 1'b1);
        step();
        chk("stall1_memwrite", 32'(memwriteE), 1);
        chk("stall1_pc", pcE, 32'h40);
        step();
        chk("stall2_memwrite", 32'(memwriteE), 1);
        chk("stall2_pc", pcE, 32'h40);
        chk("stall2_imm", immE, 32'd12);

        flushE = 1'b1;
        step();
        chk("flush_valid", 32'(validE), 0);
        chk("flush_memwrite", 32'(memwriteE), 0);
        chk("flush_pc", pcE, 32'h0);
        flushE = 1'b0; en = 1'b1;

        drive(32'hFFFFFFFF, 32'h48, 1'b1);
        step();
        chk("illegal_flag", 32'(illegalE), 1);
        chk("illegal_regwrite", 32'(regwriteE), 0);
        chk("illegal_valid", 32'(validE), 1);
        drive(32'hFFFFFFFF, 32'h4C, 1'b0);
        step();
        chk("bubble_illegal", 32'(illegalE), 0);
        chk("bubble_valid", 32'(validE), 0);

        drive(32'h00500093, 32'h50, 1'b1);
        step();
        reset = 1'b1;
        step();
        chk("midreset_valid", 32'(validE), 0);
        chk("midreset_regwrite", 32'(regwriteE), 0);
        chk("midreset_imm", immE, 32'h0);
        chk("midreset_pc", pcE, 32'h0);
        reset = 1'b0;

        drive(32'h00318233, 32'h54, 1'b1);          // x3 must be cleared by reset
        step();
        chk("rf_cleared_rd1", rd1E, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
